// File: rtl/pio_hex_display.sv
// Watches the 4-bit PIO output nibble, keeps a 4-deep history of distinct values,
// and scans that history onto a multiplexed 4-digit seven-segment display.
module pio_hex_display #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  pio_in,
    input  logic        freeze,
    input  logic        clear,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [15:0] hist,
    output logic        update_pulse
);

    localparam int              PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic            POL        = SEG_ACTIVE_LOW;

    logic [3:0]    pio_q, pio_d;
    logic [15:0]   hist_q, hist_d;
    logic [2:0]    valid_cnt_q, valid_cnt_d;
    logic          update_pulse_q, update_pulse_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic          chg;
    logic          blank;
    logic [3:0]    digit_val;
    logic [6:0]    seg_raw;
    logic [3:0]    an_raw;
    logic          dp_raw;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        pio_d          = pio_in;
        chg            = (pio_in != pio_q);
        hist_d         = hist_q;
        valid_cnt_d    = valid_cnt_q;
        update_pulse_d = 1'b0;

        // clear outranks a simultaneous change; frozen changes are lost for good
        if (clear) begin
            hist_d      = 16'h0000;
            valid_cnt_d = 3'd0;
        end else if (chg && !freeze) begin
            hist_d         = {hist_q[11:0], pio_in};
            valid_cnt_d    = (valid_cnt_q == 3'd4) ? 3'd4 : valid_cnt_q + 3'd1;
            update_pulse_d = 1'b1;
        end

        presc_d     = presc_q + PW'(1);
        digit_idx_d = digit_idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d     = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end

        digit_val = hist_q[{digit_idx_q, 2'b00} +: 4];
        blank     = ({1'b0, digit_idx_q} >= valid_cnt_q);
        seg_raw   = blank ? 7'h00 : hex_to_seg(digit_val);
        an_raw    = 4'b0001 << digit_idx_q;
        dp_raw    = (digit_idx_q == 2'd0) && freeze;

        seg_d = seg_raw ^ {7{POL}};
        an_d  = an_raw ^ {4{POL}};
        dp_d  = dp_raw ^ POL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pio_q          <= 4'h0;
            hist_q         <= 16'h0000;
            valid_cnt_q    <= 3'd0;
            update_pulse_q <= 1'b0;
            presc_q        <= '0;
            digit_idx_q    <= 2'd0;
            seg_q          <= {7{POL}};
            dp_q           <= POL;
            an_q           <= {4{POL}};
        end else begin
            pio_q          <= pio_d;
            hist_q         <= hist_d;
            valid_cnt_q    <= valid_cnt_d;
            update_pulse_q <= update_pulse_d;
            presc_q        <= presc_d;
            digit_idx_q    <= digit_idx_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            an_q           <= an_d;
        end
    end

    assign seg          = seg_q;
    assign dp           = dp_q;
    assign an           = an_q;
    assign hist         = hist_q;
    assign update_pulse = update_pulse_q;

endmodule

// File: tb/tb_pio_hex_display.sv
// Bench for pio_hex_display: a list-based history model predicts display and
// history outputs per cycle; a monitor pops and compares them.
module tb_pio_hex_display;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pio_in;
    logic        freeze;
    logic        clear;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [15:0] hist;
    logic        update_pulse;

    pio_hex_display #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .pio_in(pio_in), .freeze(freeze), .clear(clear),
        .seg(seg), .dp(dp), .an(an), .hist(hist), .update_pulse(update_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic [15:0] hist;
        logic        pulse;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] upd_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;

    // model: newest value at index 0, at most 4 entries
    int          m_vals[$];
    logic [3:0]  m_prev;
    int          m_k;
    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] model_hist();
        logic [15:0] h;
        h = 16'h0000;
        for (int i = 0; i < m_vals.size(); i++) h[4*i +: 4] = 4'(m_vals[i]);
        return h;
    endfunction

    task automatic step(input logic [3:0] p, input logic f, input logic c);
        exp_t       e;
        int         d;
        logic [3:0] onehot;
        logic       pulse;
        @(negedge clk);
        pio_in = p;
        freeze = f;
        clear  = c;
        // displayed digit comes from elapsed cycles since reset release
        d      = (m_k / SCAN_DIV) % 4;
        onehot = 4'b0001 << d;
        e.an   = ~onehot;
        e.seg  = (d < m_vals.size()) ? ~seg_tab[m_vals[d]] : 7'h7F;
        e.dp   = ~((d == 0) && f);
        pulse  = 1'b0;
        if (c) begin
            m_vals.delete();
        end else if ((p != m_prev) && !f) begin
            m_vals.push_front(int'(p));
            if (m_vals.size() > 4) void'(m_vals.pop_back());
            pulse = 1'b1;
            upd_q.push_back(model_hist());
        end
        m_prev  = p;
        e.hist  = model_hist();
        e.pulse = pulse;
        exp_q.push_back(e);
        m_k++;
    endtask

    task automatic check_reset_vals();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_hist", 32'(hist), 32'h0);
        chk("rst_pulse", 32'(update_pulse), 32'h0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2;
        reset  = 1'b0;
        m_vals.delete();
        m_prev = 4'h0;
        m_k    = 0;
        mon_en = 1'b1;
    endtask

    // asynchronous reset dropped in mid-phase, away from any clock edge
    task automatic do_reset(input logic [3:0] p);
        @(negedge clk);
        #2;
        reset  = 1'b1;
        mon_en = 1'b0;
        pio_in = p;
        freeze = 1'b0;
        clear  = 1'b0;
        #1;
        check_reset_vals();
        chk("upd_q_drained", 32'(upd_q.size()), 32'd0);
        release_reset();
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk("exp_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("an", 32'(an), 32'(e.an));
                chk("seg", 32'(seg), 32'(e.seg));
                chk("dp", 32'(dp), 32'(e.dp));
                chk("hist", 32'(hist), 32'(e.hist));
                chk("update_pulse", 32'(update_pulse), 32'(e.pulse));
            end
            if (update_pulse) begin
                if (upd_q.size() == 0) chk("spurious_update", 32'd1, 32'd0);
                else chk("update_hist", 32'(hist), 32'(upd_q.pop_front()));
            end
        end
    end

    initial begin
        logic [3:0] cur;
        reset  = 1'b1;
        pio_in = 4'h0;
        freeze = 1'b0;
        clear  = 1'b0;
        #1;
        check_reset_vals();
        release_reset();

        repeat (20) step(4'h0, 1'b0, 1'b0);
        repeat (8) step(4'h5, 1'b0, 1'b0);
        for (int v = 1; v <= 5; v++) repeat (4) step(4'(v), 1'b0, 1'b0);
        repeat (16) step(4'h5, 1'b0, 1'b0);
        repeat (10) step(4'hA, 1'b1, 1'b0);
        repeat (10) step(4'hA, 1'b0, 1'b0);
        repeat (10) step(4'hC, 1'b0, 1'b0);
        step(4'h7, 1'b0, 1'b1);
        repeat (16) step(4'h7, 1'b0, 1'b0);
        for (int v = 1; v <= 4; v++) repeat (4) step(4'(v), 1'b0, 1'b0);
        repeat (5) step(4'h4, 1'b0, 1'b0);
        do_reset(4'h4);
        repeat (16) step(4'h4, 1'b0, 1'b0);

        cur = 4'h4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                cur = 4'($urandom_range(0, 15));
                do_reset(cur);
            end else begin
                if ($urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 15));
                step(cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
            end
        end

        @(posedge clk);
        #2;
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("upd_q_empty", 32'(upd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pio_hex_display.md
Name: pio_hex_display

Overview:
- Downstream consumer of the 4-bit PIO output port: watches the nibble written by software and keeps a 4-deep history of distinct values.
- Time-multiplexes that history onto a 4-digit seven-segment display with hex decode, blanking of unfilled digits and a freeze indicator.
- Sits between the PIO out_port and the board display pins, in the same clock domain as the PIO.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range 2..2^20.
- SEG_ACTIVE_LOW, 1: 1 = seg/dp/an driven active-low (board default); 0 = active-high.

Ports:
- clk  input  1  system clock, same clock as the PIO
- reset  input  1  asynchronous, active-high reset
- pio_in  input  4  nibble from PIO out_port
- freeze  input  1  1 = ignore new values (history held)
- clear  input  1  synchronous clear of the history
- seg  output  7  segments {g,f,e,d,c,b,a}; bit0 = a
- dp  output  1  decimal point
- an  output  4  digit enables, one-hot; an[0] = rightmost digit
- hist  output  16  history {d3,d2,d1,d0}; d0 in [3:0] = newest
- update_pulse  output  1  one-cycle strobe when a value enters the history

Behaviour:
- Reset (async, active-high) state: pio_q=0, hist=0, valid_cnt=0, update_pulse=0, prescaler=0, digit_idx=0, an all off, seg all off, dp off.
  - "Off" = 1s when SEG_ACTIVE_LOW=1, 0s otherwise.
  - Reset asserted mid-scan or mid-update returns the block to this state immediately.
- Input tracking: pio_q <= pio_in every cycle, regardless of freeze or clear.
- Change detect: chg = (pio_in != pio_q).
- History update, priority order per clock edge:
  - clear=1: hist <= 0, valid_cnt <= 0, update_pulse <= 0.
  - else chg & ~freeze: hist <= {hist[11:0], pio_in}, valid_cnt <= min(valid_cnt+1, 4), update_pulse <= 1.
  - else: update_pulse <= 0; hist and valid_cnt hold.
- Update latency: a pio_in change in cycle N appears in hist[3:0] and as update_pulse=1 in cycle N+1.
  - Back-to-back changes on consecutive cycles each shift; update_pulse stays high for the run.
- A change occurring while freeze=1 is dropped permanently. Deasserting freeze does not replay it; only a later change shifts.
- After reset, a nonzero pio_in counts as a change (pio_q=0), so its first value is captured.
- valid_cnt saturates at 4; older entries fall off hist[15:12].
- Scanner:
  - Prescaler counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1: prescaler wraps to 0 and digit_idx <= digit_idx+1 mod 4 (0,1,2,3,0...).
  - Prescaler and digit_idx ignore clear and freeze.
- Display outputs are registered, one cycle after the digit_idx/hist values that drive them:
  - an: one-hot on bit digit_idx.
  - Digit value = hist[4*digit_idx +: 4].
  - Digit blanked (seg off) when digit_idx >= valid_cnt; an still scans.
  - dp lit only when digit_idx==0 and freeze=1.
- Hex decode, active-high, bit0=a: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. Invert all of seg, dp and an when SEG_ACTIVE_LOW=1.
- Simultaneous digit wrap and history update: the new hist is used from the next registered output onward. No glitch requirement beyond one-cycle latency.

Test Plan:
- Reset release, SCAN_DIV=4, SEG_ACTIVE_LOW=1, pio_in=0 -> hist=0, update_pulse never high; an cycles 1110,1101,1011,0111 every 4 cycles; seg=7F throughout (all blank).
- pio_in 0->5, hold -> next cycle hist=0005 and update_pulse=1 for exactly 1 cycle; digit0 shows seg=~6D=12, other digits blank.
- pio_in sequence 1,2,3,4,5 with 3 cycles between changes -> update_pulse count=5; final hist=2345; valid_cnt=4; no digit blank; digit3 shows ~5B.
- freeze=1, pio_in 5->A, then freeze=0 with pio_in held at A -> hist unchanged, no update_pulse; dp=0 (lit) during digit0 while frozen; a later change A->C gives hist=345C.
- clear=1 asserted in the same cycle as a change -> hist=0, valid_cnt=0, update_pulse=0; all digits blank on next scan.
- Assert reset for 1 cycle mid-digit with hist=1234 -> all outputs return to reset values asynchronously; after release, scan restarts at an=1110 with prescaler at 0.
